// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO PHY link monitor: FSM encoding, PHY register map,
// soft-reset word, speed codes and the vendor status decode.
package mdio_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_ISSUE,
        S_RST_WAIT,
        S_HOLD,
        S_BMSR_ISSUE,
        S_BMSR_WAIT,
        S_STAT_ISSUE,
        S_STAT_WAIT,
        S_UPDATE
    } state_t;

    localparam logic [4:0]  BMCR_ADDR     = 5'h00;
    localparam logic [4:0]  BMSR_ADDR     = 5'h01;
    localparam logic [15:0] SOFT_RST_WORD = 16'h9140;

    localparam logic [1:0] SPD_10    = 2'b00;
    localparam logic [1:0] SPD_100   = 2'b01;
    localparam logic [1:0] SPD_1000  = 2'b10;
    localparam logic [1:0] SPD_UNRES = 2'b11;

    typedef struct packed {
        logic       link_up;
        logic [1:0] speed;
        logic       full_duplex;
    } link_t;

    // Bit 11 flags a resolved link; speed and duplex are meaningless until then.
    function automatic link_t decode_status(input logic [15:0] stat);
        link_t l;
        if (stat[11]) l = '{1'b1, stat[15:14], stat[13]};
        else          l = '{1'b0, SPD_UNRES, 1'b0};
        return l;
    endfunction

endpackage

// File: rtl/mdio_tmr.sv
// Loadable down-counter that stops at zero; expired is high while the count is zero.
module mdio_tmr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)              cnt <= '0;
        else if (load)        cnt <= load_val;
        else if (cnt != '0)   cnt <= cnt - W'(1);
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/mdio_link_mon.sv
// Periodically polls a PHY over an MDIO driver (BMSR, then vendor status) and
// resolves link/speed/duplex; also serves soft-reset requests between polls.
module mdio_link_mon
    import mdio_pkg::*;
#(
    parameter logic [31:0] POLL_CYCLES     = 32'd1_000_000,
    parameter logic [15:0] TIMEOUT_CYCLES  = 16'd4096,
    parameter logic [31:0] RST_HOLD_CYCLES = 32'd50_000,
    parameter logic [4:0]  STAT_REG        = 5'h11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        soft_rst_req,
    output logic        op_exec,
    output logic        op_rh_wl,
    output logic [4:0]  op_addr,
    output logic [15:0] op_wr_data,
    input  logic        op_done,
    input  logic [15:0] op_rd_data,
    input  logic        op_rd_ack,
    output logic        link_up,
    output logic [1:0]  speed_mode,
    output logic        full_duplex,
    output logic        status_valid,
    output logic        link_change,
    output logic        err_timeout,
    output logic        busy
);

    localparam logic [31:0] POLL_LOAD = POLL_CYCLES - 32'd1;
    localparam logic [31:0] TMO_LOAD  = 32'(TIMEOUT_CYCLES) - 32'd1;
    localparam logic [31:0] HOLD_LOAD = RST_HOLD_CYCLES - 32'd1;

    state_t      state;
    logic        rst_pend;
    logic [15:0] stat_q;
    logic        tmr_load;
    logic [31:0] tmr_val;
    logic        tmr_exp;
    link_t       nxt;

    wire rst_go   = rst_pend | soft_rst_req;
    wire done_ok  = op_done & ~op_rd_ack;
    wire done_nak = op_done &  op_rd_ack;

    assign nxt  = decode_status(stat_q);
    assign busy = (state != S_IDLE);

    // One timer serves poll interval, transaction timeout and reset hold-off; it is
    // reloaded on the edge that enters the phase it times.
    // NOTE: defaults first so every path assigns tmr_load/tmr_val and no latch is inferred.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = TMO_LOAD;
        unique case (state)
            S_IDLE:     tmr_load = rst_go | tmr_exp;
            S_HOLD:     tmr_load = tmr_exp;
            S_RST_WAIT: begin
                tmr_load = op_done | tmr_exp;
                tmr_val  = HOLD_LOAD;
            end
            S_BMSR_WAIT: begin
                if (done_ok) begin
                    tmr_load = op_rd_data[2];
                end else begin
                    tmr_load = done_nak | tmr_exp;
                    tmr_val  = POLL_LOAD;
                end
            end
            S_STAT_WAIT: begin
                if (!done_ok) begin
                    tmr_load = done_nak | tmr_exp;
                    tmr_val  = POLL_LOAD;
                end
            end
            S_UPDATE: begin
                tmr_load = 1'b1;
                tmr_val  = POLL_LOAD;
            end
            default: ;
        endcase
    end

    mdio_tmr #(.W(32)) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            rst_pend     <= 1'b0;
            stat_q       <= '0;
            op_exec      <= 1'b0;
            op_rh_wl     <= 1'b0;
            op_addr      <= '0;
            op_wr_data   <= '0;
            link_up      <= 1'b0;
            speed_mode   <= SPD_UNRES;
            full_duplex  <= 1'b0;
            status_valid <= 1'b0;
            link_change  <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            op_exec     <= 1'b0;
            link_change <= 1'b0;
            err_timeout <= 1'b0;
            if (soft_rst_req) rst_pend <= 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (rst_go) begin
                        state        <= S_RST_ISSUE;
                        rst_pend     <= 1'b0;
                        status_valid <= 1'b0;
                        op_exec      <= 1'b1;
                        op_rh_wl     <= 1'b0;
                        op_addr      <= BMCR_ADDR;
                        op_wr_data   <= SOFT_RST_WORD;
                    end else if (tmr_exp) begin
                        state      <= S_BMSR_ISSUE;
                        op_exec    <= 1'b1;
                        op_rh_wl   <= 1'b1;
                        op_addr    <= BMSR_ADDR;
                        op_wr_data <= '0;
                    end
                end
                S_RST_ISSUE:  state <= S_RST_WAIT;
                S_BMSR_ISSUE: state <= S_BMSR_WAIT;
                S_STAT_ISSUE: state <= S_STAT_WAIT;
                S_RST_WAIT: begin
                    if (op_done) begin
                        state <= S_HOLD;
                    end else if (tmr_exp) begin
                        state       <= S_HOLD;
                        err_timeout <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (tmr_exp) begin
                        state      <= S_BMSR_ISSUE;
                        op_exec    <= 1'b1;
                        op_rh_wl   <= 1'b1;
                        op_addr    <= BMSR_ADDR;
                        op_wr_data <= '0;
                    end
                end
                S_BMSR_WAIT: begin
                    if (done_ok) begin
                        if (op_rd_data[2]) begin
                            state    <= S_STAT_ISSUE;
                            op_exec  <= 1'b1;
                            op_rh_wl <= 1'b1;
                            op_addr  <= STAT_REG;
                        end else begin
                            // Link down in BMSR: feed UPDATE an unresolved status word.
                            stat_q <= '0;
                            state  <= S_UPDATE;
                        end
                    end else if (done_nak) begin
                        status_valid <= 1'b0;
                        state        <= S_IDLE;
                    end else if (tmr_exp) begin
                        err_timeout  <= 1'b1;
                        status_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                S_STAT_WAIT: begin
                    if (done_ok) begin
                        stat_q <= op_rd_data;
                        state  <= S_UPDATE;
                    end else if (done_nak) begin
                        status_valid <= 1'b0;
                        state        <= S_IDLE;
                    end else if (tmr_exp) begin
                        err_timeout  <= 1'b1;
                        status_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                S_UPDATE: begin
                    link_up      <= nxt.link_up;
                    speed_mode   <= nxt.speed;
                    full_duplex  <= nxt.full_duplex;
                    status_valid <= 1'b1;
                    link_change  <= (nxt.link_up != link_up) || (nxt.speed != speed_mode)
                                    || (nxt.full_duplex != full_duplex);
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_link_mon.sv
// Directed bench for mdio_link_mon with short poll/timeout/hold-off parameters;
// a scripted PHY answers each transaction and expectations are hand-derived.
module tb_mdio_link_mon;
    import mdio_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        soft_rst_req;
    logic        op_exec;
    logic        op_rh_wl;
    logic [4:0]  op_addr;
    logic [15:0] op_wr_data;
    logic        op_done;
    logic [15:0] op_rd_data;
    logic        op_rd_ack;
    logic        link_up;
    logic [1:0]  speed_mode;
    logic        full_duplex;
    logic        status_valid;
    logic        link_change;
    logic        err_timeout;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int lc_cnt = 0;
    int wr_cnt = 0;
    int to_cnt = 0;
    int n;

    mdio_link_mon #(
        .POLL_CYCLES     (32'd100),
        .TIMEOUT_CYCLES  (16'd50),
        .RST_HOLD_CYCLES (32'd20),
        .STAT_REG        (5'h11)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_req (soft_rst_req),
        .op_exec      (op_exec),
        .op_rh_wl     (op_rh_wl),
        .op_addr      (op_addr),
        .op_wr_data   (op_wr_data),
        .op_done      (op_done),
        .op_rd_data   (op_rd_data),
        .op_rd_ack    (op_rd_ack),
        .link_up      (link_up),
        .speed_mode   (speed_mode),
        .full_duplex  (full_duplex),
        .status_valid (status_valid),
        .link_change  (link_change),
        .err_timeout  (err_timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Pulse tallies, sampled mid-cycle.
    always @(negedge clk) begin
        if (link_change)            lc_cnt <= lc_cnt + 1;
        if (op_exec && !op_rh_wl)   wr_cnt <= wr_cnt + 1;
        if (err_timeout)            to_cnt <= to_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge where op_exec is seen; answers one cycle later.
    task automatic serve(input logic [15:0] d, input logic ack);
        @(negedge clk);
        op_done    = 1'b1;
        op_rd_data = d;
        op_rd_ack  = ack;
        @(negedge clk);
        op_done    = 1'b0;
        op_rd_ack  = 1'b0;
    endtask

    // Counts negedges until op_exec (or err_timeout) is seen, bounded.
    task automatic wait_for(input bit want_tmo, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(want_tmo ? err_timeout : op_exec) && cnt < 300);
    endtask

    initial begin
        rst = 1'b1; soft_rst_req = 1'b0;
        op_done = 1'b0; op_rd_data = '0; op_rd_ack = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_exec",   op_exec, 0);
        check("rst_rhwl",   op_rh_wl, 0);
        check("rst_addr",   op_addr, 0);
        check("rst_wdata",  op_wr_data, 0);
        check("rst_link",   link_up, 0);
        check("rst_speed",  speed_mode, SPD_UNRES);
        check("rst_dup",    full_duplex, 0);
        check("rst_valid",  status_valid, 0);
        check("rst_lchg",   link_change, 0);
        check("rst_tmo",    err_timeout, 0);
        check("rst_busy",   busy, 0);
        rst = 1'b0;

        // First poll on the 2nd cycle; BMSR link bit clear -> no status read.
        @(negedge clk);
        check("p1_exec", op_exec, 1);
        check("p1_addr", op_addr, BMSR_ADDR);
        check("p1_rhwl", op_rh_wl, 1);
        check("p1_busy", busy, 1);
        serve(16'h7969, 1'b0);
        check("p1_nostat", op_exec, 0);
        @(negedge clk);
        check("p1_link",  link_up, 0);
        check("p1_speed", speed_mode, SPD_UNRES);
        check("p1_valid", status_valid, 1);
        check("p1_lchg",  link_change, 0);
        check("p1_busy0", busy, 0);

        // Stray op_done while idle must be ignored.
        repeat (5) @(negedge clk);
        op_done = 1'b1; op_rd_data = 16'hFFFF;
        @(negedge clk);
        op_done = 1'b0;
        @(negedge clk);
        check("idle_done_busy",  busy, 0);
        check("idle_done_valid", status_valid, 1);
        check("idle_done_link",  link_up, 0);
        wait_for(1'b0, n);
        check("p2_interval", n, 93);

        // Link up at 1000M full duplex.
        serve(16'h796D, 1'b0);
        check("p2_stat_exec", op_exec, 1);
        check("p2_stat_addr", op_addr, 5'h11);
        check("p2_stat_rhwl", op_rh_wl, 1);
        serve(16'hAC00, 1'b0);
        @(negedge clk);
        check("p2_link",  link_up, 1);
        check("p2_speed", speed_mode, SPD_1000);
        check("p2_dup",   full_duplex, 1);
        check("p2_valid", status_valid, 1);
        check("p2_lchg",  link_change, 1);
        wait_for(1'b0, n);
        check("p3_interval", n, 100);
        check("p2_one_pulse", lc_cnt, 1);

        // BMSR NAK: status invalid, link outputs held, timer reloaded.
        serve(16'h0000, 1'b1);
        check("nak_valid", status_valid, 0);
        check("nak_link",  link_up, 1);
        check("nak_speed", speed_mode, SPD_1000);
        check("nak_dup",   full_duplex, 1);
        check("nak_busy",  busy, 0);
        wait_for(1'b0, n);
        check("nak_interval", n, 100);

        // op_done withheld: timeout after 50 cycles, then polling resumes.
        wait_for(1'b1, n);
        check("tmo_latency", n, 50);
        check("tmo_valid",   status_valid, 0);
        check("tmo_link",    link_up, 1);
        wait_for(1'b0, n);
        check("tmo_resume", n, 100);
        check("tmo_addr",   op_addr, BMSR_ADDR);

        // Two soft-reset requests during STAT_WAIT: read completes, one write follows.
        serve(16'h796D, 1'b0);
        @(negedge clk); soft_rst_req = 1'b1;
        @(negedge clk); soft_rst_req = 1'b0;
        @(negedge clk); soft_rst_req = 1'b1;
        @(negedge clk); soft_rst_req = 1'b0;
        op_done = 1'b1; op_rd_data = 16'h6800; op_rd_ack = 1'b0;
        @(negedge clk); op_done = 1'b0;
        @(negedge clk);
        check("sr_speed", speed_mode, SPD_100);
        check("sr_lchg",  link_change, 1);
        check("sr_valid", status_valid, 1);
        @(negedge clk);
        check("sr_exec",  op_exec, 1);
        check("sr_rhwl",  op_rh_wl, 0);
        check("sr_addr",  op_addr, BMCR_ADDR);
        check("sr_wdata", op_wr_data, SOFT_RST_WORD);
        check("sr_valid0", status_valid, 0);
        serve(16'h0000, 1'b0);
        wait_for(1'b0, n);
        check("hold_len",  n, 20);
        check("hold_addr", op_addr, BMSR_ADDR);
        check("hold_rhwl", op_rh_wl, 1);

        // Link drops; the merged request must not produce a second write.
        serve(16'h7969, 1'b0);
        @(negedge clk);
        check("dn_link",  link_up, 0);
        check("dn_speed", speed_mode, SPD_UNRES);
        check("dn_lchg",  link_change, 1);
        wait_for(1'b0, n);
        check("dn_interval", n, 100);
        check("dn_no_rewrite", op_rh_wl, 1);

        // Soft reset on the poll-expiry cycle wins over the BMSR read.
        serve(16'h7969, 1'b0);
        @(negedge clk);
        check("q_lchg", link_change, 0);
        repeat (99) @(negedge clk);
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        check("coin_exec", op_exec, 1);
        check("coin_rhwl", op_rh_wl, 0);
        check("coin_addr", op_addr, BMCR_ADDR);
        serve(16'h0000, 1'b0);
        wait_for(1'b0, n);
        check("coin_hold", n, 20);

        // Reset mid-transaction: everything returns to reset state, no pulses.
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_busy",  busy, 0);
        check("mid_exec",  op_exec, 0);
        check("mid_speed", speed_mode, SPD_UNRES);
        check("mid_tmo",   err_timeout, 0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_restart", op_exec, 1);
        repeat (3) @(negedge clk);

        check("cnt_tmo",   to_cnt, 1);
        check("cnt_write", wr_cnt, 2);
        check("cnt_lchg",  lc_cnt, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
